// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction-memory responder serving 4-byte opcode windows
module imem_responder #(
   parameter int          ADDR_BITS = 8,
   parameter logic [7:0]  FILL_BYTE = 8'h90
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req,
   input  logic [31:0]          req_addr,
   output logic                 busy,
   output logic                 rsp_valid,
   output logic [31:0]          rsp_data,
   output logic                 rsp_oor,
   input  logic                 rsp_ack,
   input  logic                 load_en,
   input  logic [ADDR_BITS-1:0] load_addr,
   input  logic [7:0]           load_data,
   output logic                 load_drop
);

   localparam int DEPTH = 1 << ADDR_BITS;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t               state;
   state_t               state_nx;
   logic [1:0]           cnt;
   logic [31:0]          addr_q;
   logic [7:0]           mem [0:DEPTH-1];

   logic [31:0]          byte_addr;
   logic                 byte_oor;
   logic [7:0]           byte_val;
   logic                 accept;
   logic                 load_ok;

   // Address of the byte read this cycle wraps at 2**32; anything above the
   // array depth is filled rather than aliased back into the array.
   assign byte_addr = addr_q + {30'd0, cnt};
   assign byte_oor  = |byte_addr[31:ADDR_BITS];
   assign byte_val  = byte_oor ? FILL_BYTE : mem[byte_addr[ADDR_BITS-1:0]];

   assign accept    = (state == IDLE) && req;
   assign load_ok   = (state == IDLE) && load_en;

   assign busy      = (state != IDLE);
   assign rsp_valid = (state == RESP);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic: one read per cycle for four cycles, then hold the window.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (req) state_nx = READ;
         READ: if (cnt == 2'd3) state_nx = RESP;
         RESP: if (rsp_ack) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Datapath: capture the address on accept, shift bytes in MSB-first, flag drops.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= 2'd0;
         addr_q    <= 32'd0;
         rsp_data  <= 32'd0;
         rsp_oor   <= 1'b0;
         load_drop <= 1'b0;
      end else begin
         load_drop <= load_en && (state != IDLE);
         if (accept) begin
            addr_q  <= req_addr;
            cnt     <= 2'd0;
            rsp_oor <= 1'b0;
         end
         if (state == READ) begin
            rsp_data <= {rsp_data[23:0], byte_val};
            rsp_oor  <= rsp_oor | byte_oor;
            cnt      <= cnt + 2'd1;
         end
      end
   end

   // Byte array write port; contents survive reset, writes only while idle.
   always_ff @(posedge clk) begin
      if (!reset && load_ok) begin
         mem[load_addr] <= load_data;
      end
   end

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - randomized self-checking bench with behavioural model
module tb_imem_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic        busy;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_oor;
   logic        rsp_ack = 1'b0;
   logic        load_en = 1'b0;
   logic [7:0]  load_addr = 8'd0;
   logic [7:0]  load_data = 8'd0;
   logic        load_drop;

   int n_checks = 0;
   int n_errors = 0;

   // Model: byte image plus "cycles since accept" (0 = idle, 5 = window valid).
   logic [7:0]  m_mem [256];
   int          m_t = 0;
   logic [31:0] m_data = 32'd0;
   logic        m_oor = 1'b0;
   logic        m_drop = 1'b0;

   imem_responder #(.ADDR_BITS(8), .FILL_BYTE(8'h90)) dut (
      .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
      .busy(busy), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_oor(rsp_oor),
      .rsp_ack(rsp_ack), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .load_drop(load_drop)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Window the fetch unit must see for address a, from the current image.
   task automatic model_window(input logic [31:0] a);
      logic [31:0] ba;
      logic [7:0]  b;
      m_data = 32'd0;
      m_oor  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ba = a + i;
         if (ba < 32'd256) begin
            b = m_mem[ba[7:0]];
         end else begin
            b = 8'h90;
            m_oor = 1'b1;
         end
         m_data[31-8*i -: 8] = b;
      end
   endtask

   task automatic compare_outputs();
      chk("busy", {31'd0, busy}, {31'd0, m_t != 0});
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_t == 5});
      chk("load_drop", {31'd0, load_drop}, {31'd0, m_drop});
      if (m_t == 5) begin
         chk("rsp_data", rsp_data, m_data);
         chk("rsp_oor", {31'd0, rsp_oor}, {31'd0, m_oor});
      end
   endtask

   // One clock: drive inputs at negedge, advance model, sample at next negedge.
   task automatic step(input logic r, input logic q, input logic [31:0] a,
                       input logic k, input logic le, input logic [7:0] la,
                       input logic [7:0] ld);
      reset = r; req = q; req_addr = a; rsp_ack = k;
      load_en = le; load_addr = la; load_data = ld;
      if (r) begin
         m_t = 0;
         m_drop = 1'b0;
      end else begin
         m_drop = le && (m_t != 0);
         if (m_t == 0) begin
            if (le) m_mem[la] = ld;
            if (q) begin
               model_window(a);
               m_t = 1;
            end
         end else if (m_t < 5) begin
            m_t++;
         end else if (k) begin
            m_t = 0;
         end
      end
      @(posedge clk);
      @(negedge clk);
      compare_outputs();
   endtask

   task automatic idle_step();
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 8'd0, 8'd0);
   endtask

   task automatic req_step(input logic [31:0] a);
      step(1'b0, 1'b1, a, 1'b0, 1'b0, 8'd0, 8'd0);
   endtask

   task automatic load_step(input logic [7:0] la, input logic [7:0] ld);
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, la, ld);
   endtask

   task automatic ack_step();
      step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 8'd0, 8'd0);
   endtask

   initial begin
      logic [31:0] held;
      logic [31:0] ra;
      @(negedge clk);
      step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 8'd0, 8'd0);
      step(1'b1, 1'b1, 32'd0, 1'b1, 1'b1, 8'd0, 8'd0);
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("reset rsp_data", rsp_data, 32'd0);
      chk("reset rsp_oor", {31'd0, rsp_oor}, 32'd0);
      chk("reset load_drop", {31'd0, load_drop}, 32'd0);

      for (int i = 0; i < 256; i++) load_step(i[7:0], 8'($urandom));

      // Basic window and latency.
      load_step(8'h00, 8'h55); load_step(8'h01, 8'h89);
      load_step(8'h02, 8'he5); load_step(8'h03, 8'hb8);
      req_step(32'd0);
      idle_step(); idle_step(); idle_step();
      chk("latency not yet valid", {31'd0, rsp_valid}, 32'd0);
      idle_step();
      chk("latency valid", {31'd0, rsp_valid}, 32'd1);
      chk("window 0", rsp_data, 32'h5589e5b8);
      chk("window 0 oor", {31'd0, rsp_oor}, 32'd0);

      // Hold ack low; window must stay put.
      held = rsp_data;
      for (int i = 0; i < 10; i++) idle_step();
      chk("held valid", {31'd0, rsp_valid}, 32'd1);
      chk("held data", rsp_data, held);
      ack_step();
      chk("ack to idle", {31'd0, busy}, 32'd0);

      // Top of array: fill bytes and oor flag.
      load_step(8'hfe, 8'hc3); load_step(8'hff, 8'h90);
      req_step(32'h0000_00fe);
      for (int i = 0; i < 4; i++) idle_step();
      chk("window fe", rsp_data, 32'hc3909090);
      chk("window fe oor", {31'd0, rsp_oor}, 32'd1);
      ack_step();

      // req during READ ignored, not queued.
      req_step(32'd0);
      req_step(32'h0000_00fe);
      idle_step(); idle_step(); idle_step();
      chk("ignored req data", rsp_data, 32'h5589e5b8);
      ack_step();
      idle_step();
      chk("no queued req", {31'd0, busy}, 32'd0);

      // Load while busy is dropped; same-edge load+req is seen.
      req_step(32'd0);
      load_step(8'h01, 8'h11);
      chk("load_drop pulse", {31'd0, load_drop}, 32'd1);
      idle_step();
      chk("load_drop one cycle", {31'd0, load_drop}, 32'd0);
      idle_step(); idle_step();
      chk("dropped load unchanged", rsp_data, 32'h5589e5b8);
      ack_step();
      step(1'b0, 1'b1, 32'd0, 1'b0, 1'b1, 8'h02, 8'h77);
      for (int i = 0; i < 4; i++) idle_step();
      chk("same-edge load", rsp_data, 32'h558977b8);
      ack_step();

      // Reset in the middle of READ abandons the response.
      req_step(32'h10);
      idle_step(); idle_step();
      step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 8'd0, 8'd0);
      chk("mid-read reset busy", {31'd0, busy}, 32'd0);
      for (int i = 0; i < 6; i++) idle_step();
      chk("no abandoned valid", {31'd0, rsp_valid}, 32'd0);
      req_step(32'd0);
      for (int i = 0; i < 4; i++) idle_step();
      chk("mem retained", rsp_data, 32'h558977b8);
      ack_step();

      // Randomized traffic including wrap at 2**32 and sporadic resets.
      for (int i = 0; i < 4000; i++) begin
         case ($urandom_range(0, 3))
            0: ra = 32'($urandom_range(0, 255));
            1: ra = 32'($urandom_range(32'hfc, 32'h103));
            2: ra = 32'hffff_fffc + 32'($urandom_range(0, 3));
            default: ra = $urandom;
         endcase
         step($urandom_range(0, 63) == 0, $urandom_range(0, 2) == 0, ra,
              $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
              8'($urandom), 8'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
